// File: rtl/conv1x1_pointwise_acc.sv
// conv1x1_pointwise_acc
//   Pointwise (1x1, stride 1) convolution core. Each output pixel is built
//   from C_IN channel beats: the signed data*weight products are summed, and
//   the bias is added on the last beat. The sum is then rounded half-up to
//   the output Q format, optionally clamped at zero (ReLU) and saturated to
//   DATA_W bits.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous abort: drops the partial sum and any held result
//   in_valid   upstream beat valid
//   in_ready   core can take a beat (combinational from out_ready in OUT)
//   in_data    activation for the current channel (signed QDATA_W.FRAC_W)
//   in_weight  weight for the current channel (signed)
//   bias_in    bias, sampled only on the last channel beat (signed)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result pixel (signed)
//   acc_busy   a partial sum is in progress (channel count != 0)
module conv1x1_pointwise_acc #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int C_IN    = 4,
  parameter int ACC_W   = 40,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [DATA_W-1:0] bias_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              acc_busy
);

  // Keep the counter at least one bit wide so C_IN=1 still elaborates.
  localparam int CNT_W = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(C_IN - 1);

  // Half an output LSB; zero when there are no fractional bits.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((2 ** FRAC_W) >> 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;

  logic                      beat;
  logic                      last_beat;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   final_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [ACC_W-1:0]   relu_val;
  logic [DATA_W-1:0]         sat_val;

  // In OUT a beat may be taken in the same cycle the held result leaves,
  // which is what allows back-to-back pixels without a bubble.
  assign in_ready  = (state_q == ST_ACC) || out_ready;
  assign beat      = in_valid && in_ready;
  assign last_beat = (count_q == LAST_CNT);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc_busy  = (count_q != '0);

  // Datapath: product, running sum, bias alignment, rounding, ReLU, saturation.
  always_comb begin
    product     = $signed(in_data) * $signed(in_weight);
    product_ext = ACC_W'(product);
    // Bias shares the output Q format, so it is shifted up to the product's
    // 2*FRAC_W fractional position before being added.
    bias_ext    = ACC_W'($signed(bias_in)) <<< FRAC_W;
    acc_sum     = acc_q + product_ext;
    final_sum   = acc_sum + bias_ext + RND;
    shifted     = final_sum >>> FRAC_W;
    relu_val    = ((RELU_EN != 0) && (shifted < 0)) ? '0 : shifted;
    if (relu_val > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (relu_val < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = relu_val[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = ST_ACC;
      count_d     = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      // Held result handed off; may be overridden below by a new result.
      if ((state_q == ST_OUT) && out_ready) begin
        state_d     = ST_ACC;
        out_valid_d = 1'b0;
      end
      if (beat) begin
        if (last_beat) begin
          out_data_d  = sat_val;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
          acc_d       = '0;
          count_d     = '0;
        end else begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/conv1x1_pointwise_acc.md
Name: conv1x1_pointwise_acc

Overview:
- Parametrised pointwise (1x1, stride 1) convolution core that accumulates C_IN channel products per output pixel, adds a bias, rounds, saturates and optionally applies ReLU.
- Successor to the single-product 1x1 convolution. Adds signed fixed-point width control, multi-channel accumulation, valid/ready backpressure and a synchronous abort.
- Sits between the feature-map line streamer (upstream) and the activation/pool writer (downstream).

Parameters:
- DATA_W, 16, signed width of data, weight, bias and output (two's complement).
- FRAC_W, 8, fractional bits of data, weight, bias and output (Q format). Range 0..DATA_W-1.
- C_IN, 4, input-channel beats accumulated per output pixel. Must be at least 1.
- ACC_W, 40, accumulator width. Must be at least 2*DATA_W + clog2(C_IN) + 1.
- RELU_EN, 1, 1 clamps negative results to 0; 0 passes signed results.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort of the current pixel
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  activation for current channel
- in_weight  in  DATA_W  weight for current channel
- bias_in  in  DATA_W  bias, sampled on the last channel beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result pixel
- acc_busy  out  1  partial sum in progress (channel count != 0)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ACC, channel count=0, acc=0.
  - out_valid=0, out_data=0, acc_busy=0.
  - in_ready goes to 1 after reset release.
- States are ACC (collecting beats) and OUT (holding a result).
- in_ready = (state==ACC) OR (state==OUT AND out_ready). It is combinational from out_ready.
- Beat = in_valid AND in_ready. Each beat:
  - product = signed in_data * signed in_weight, 2*DATA_W bits, 2*FRAC_W fractional bits, sign-extended to ACC_W.
  - acc <= acc + product; count increments.
- Last beat (count == C_IN-1):
  - final = acc + product + (sign-extended bias_in << FRAC_W).
  - Round half-up: add 2^(FRAC_W-1) when FRAC_W>0, then arithmetic shift right by FRAC_W.
  - If RELU_EN and the result is negative, the result is 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the result into out_data, set out_valid=1, go to OUT, and set acc=0, count=0.
- Latency: out_valid rises the cycle after the last beat.
- When C_IN=1, every beat is a last beat.
- OUT state:
  - out_data and out_valid stay stable while out_ready=0.
  - When out_ready=1, the result transfers. Next cycle out_valid=0 and state=ACC, unless that same cycle's accepted beat was itself a last beat (only possible when C_IN=1). In that case out_valid stays 1 with the new data.
  - A beat accepted in OUT with out_ready=1 is channel 0 of the next pixel. This sustains 1 pixel per C_IN cycles with no bubble.
- clear=1 has highest priority after reset:
  - Next cycle acc=0, count=0, state=ACC, out_valid=0.
  - Any beat presented that cycle is discarded.
  - A held result is dropped.
- acc_busy = (count != 0).
- No overflow is possible in acc under the ACC_W rule. Saturation applies only at output.
- in_data, in_weight and bias_in are don't-care when not sampled.

Test Plan:
- Reset, then 4 beats in_data=256 (1.0), in_weight=512 (2.0), bias_in=128 (0.5), out_ready=1 -> out_valid=1 exactly one cycle after beat 4, out_data=2176 (8.5). Next cycle out_valid=0.
- 4 beats in_data=32767, in_weight=32767, bias 0 -> out_data=32767 (saturated). With in_data=-32768, in_weight=32767 and RELU_EN=0 -> out_data=-32768.
- ReLU: 4 beats 256 x -256, bias 0 -> RELU_EN=1 gives out_data=0; RELU_EN=0 gives out_data=0xFC00 (-1024).
- Rounding: C_IN=1, in_data=1, in_weight=128, bias 0 -> out_data=1. in_data=1, in_weight=127 -> out_data=0.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> out_data unchanged, out_valid=1, in_ready=0. Raise out_ready with in_valid=1 -> beat accepted the same cycle as channel 0 of the next pixel. Continuous streaming gives one result every C_IN cycles.
- Abort and reset:
  - 2 beats, then clear=1 -> acc_busy=0; the next 4 beats produce a result from those 4 only.
  - 2 beats, then rst=0 mid-pixel -> out_valid=0 and acc_busy=0 immediately (asynchronous); the following pixel is correct.
